// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and FSM encoding for the data-memory arbiter.
// The arbiter and its address checker both import this package.
package dmem_arbiter_pkg;

  localparam logic        ENABLED        = 1'b1;
  localparam logic        WRITE_ENABLED  = 1'b1;
  localparam logic        WRITE_DISABLED = 1'b0;
  localparam logic [31:0] DMEM_BASE      = 32'h1001_0000;
  localparam int          DMEM_DEPTH     = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational range and alignment check for a byte address into the data memory.
// The subtraction wraps, so addresses below the base produce a huge index and fail the range test.
module dmem_addr_check
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE,
  parameter int          DEPTH     = DMEM_DEPTH
) (
  input  logic [31:0] addr_i,
  output logic        legal_o,
  output logic [29:0] word_idx_o
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  assign word_idx_o = 30'((addr_i - BASE_ADDR) >> 2);
  assign legal_o    = (word_idx_o < DEPTH_W) && (addr_i[1:0] == 2'b00);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: cpu has fixed priority,
// aux is forced in after STARVE_LIMIT consecutive cpu grants while it waits.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DMEM_BASE,
  parameter int          DEPTH        = DMEM_DEPTH,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic [31:0] aux_rdata,
  output logic        aux_ack,
  output logic        aux_err,
  output logic        mem_ena,
  output logic        mem_wena,
  output logic        mem_w_cs,
  output logic        mem_r_cs,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state_o,
  output logic [29:0] dbg_word_idx_o
);

  // Handshake: a port raises req and holds it (with we/addr/wdata stable) until its
  // one-cycle ack; err and rdata are valid with ack, rdata then holds until the next ack.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        lat_aux_q, lat_aux_d;
  logic        lat_we_q, lat_we_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [3:0]  starve_q, starve_d;
  logic        cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
  logic        aux_ack_q, aux_ack_d, aux_err_q, aux_err_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d, aux_rdata_q, aux_rdata_d;
  logic        grant_aux;
  logic [31:0] xfer_rdata;
  logic        lat_legal;

  dmem_addr_check #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_addr_check (
    .addr_i     (lat_addr_q),
    .legal_o    (lat_legal),
    .word_idx_o (dbg_word_idx_o)
  );

  always_comb begin
    state_d     = state_q;
    lat_aux_d   = lat_aux_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    starve_d    = starve_q;
    grant_aux   = 1'b0;
    xfer_rdata  = '0;
    cpu_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    aux_ack_d   = 1'b0;
    aux_err_d   = 1'b0;
    aux_rdata_d = aux_rdata_q;
    mem_ena     = 1'b0;
    mem_wena    = WRITE_DISABLED;
    mem_w_cs    = 1'b0;
    mem_r_cs    = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || aux_req) begin
          grant_aux   = aux_req && (!cpu_req || starve_q == LIMIT);
          lat_aux_d   = grant_aux;
          lat_we_d    = grant_aux ? aux_we    : cpu_we;
          lat_addr_d  = grant_aux ? aux_addr  : cpu_addr;
          lat_wdata_d = grant_aux ? aux_wdata : cpu_wdata;
          if (grant_aux || !aux_req) starve_d = '0;
          else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        mem_addr  = lat_addr_q;
        mem_wdata = lat_wdata_q;
        // Controls are gated with rst so a write caught by reset never lands.
        if (lat_legal && !rst) begin
          mem_ena  = ENABLED;
          mem_wena = lat_we_q ? WRITE_ENABLED : WRITE_DISABLED;
          mem_w_cs = lat_we_q;
          mem_r_cs = !lat_we_q;
        end
        if (lat_legal && !lat_we_q) xfer_rdata = mem_rdata;
        if (lat_aux_q) begin
          aux_ack_d   = 1'b1;
          aux_err_d   = !lat_legal;
          aux_rdata_d = xfer_rdata;
        end else begin
          cpu_ack_d   = 1'b1;
          cpu_err_d   = !lat_legal;
          cpu_rdata_d = xfer_rdata;
        end
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lat_aux_q   <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      starve_q    <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      aux_ack_q   <= 1'b0;
      aux_err_q   <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_aux_q   <= lat_aux_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      starve_q    <= starve_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_ack_q   <= aux_ack_d;
      aux_err_q   <= aux_err_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign cpu_err     = cpu_err_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign aux_ack     = aux_ack_q;
  assign aux_err     = aux_err_q;
  assign aux_rdata   = aux_rdata_q;
  assign cpu_stall   = cpu_req && !cpu_ack_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory (1024 x 32, word-addressed, base 0x10010000) between two requesters: the pipeline MEM stage (cpu port) and an auxiliary port used by the display/debug reader and the memory loader.
- Fixed priority to the cpu port, with a starvation guard for aux.
- Performs the address range/alignment check and drives the memory's ena/wena/w_cs/r_cs controls.
- Returns registered read data with a one-cycle ack per port, plus a stall to the pipeline.

Parameters:
BASE_ADDR, 32'h10010000, byte address of memory word 0
DEPTH, 1024, number of 32-bit words; legal bytes BASE_ADDR .. BASE_ADDR+4*DEPTH-1
STARVE_LIMIT, 4, consecutive cpu grants while aux waits before aux is forced in (range 1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  cpu access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  32  byte address
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data, valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  valid with cpu_ack; address out of range or misaligned
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational), to pipeline hazard unit
aux_req, aux_we, aux_addr, aux_wdata, aux_rdata, aux_ack, aux_err  same as cpu_* for aux port
mem_ena  out  1  memory enable
mem_wena  out  1  memory write enable
mem_w_cs  out  1  write chip select
mem_r_cs  out  1  read chip select
mem_addr  out  32  byte address to memory
mem_wdata  out  32  write data to memory
mem_rdata  in  32  combinational read data from memory

Behaviour:
- FSM states: IDLE, XFER, RESP. Reset puts the FSM in IDLE.
- Reset values: all acks, errs and rdata are 0; starve counter is 0; latched request registers are 0; all mem_* are 0.
- IDLE:
  - If any req is high, arbitrate, latch the winner (port id, we, addr, wdata) and go to XFER.
  - Winner is cpu, unless aux_req=1 and starve_cnt==STARVE_LIMIT, in which case aux wins.
- Starve counter:
  - Increments when cpu wins while aux_req=1 (saturates at STARVE_LIMIT).
  - Clears when aux wins or when aux_req=0 at arbitration.
- XFER (exactly one cycle):
  - Drive mem_addr and mem_wdata from the latched registers.
  - If the latched address is legal: mem_ena=1; mem_wena=mem_w_cs=we; mem_r_cs=~we.
  - If illegal (outside range, or addr[1:0]!=0): all mem controls stay 0, so no access occurs.
  - On exit, capture mem_rdata into the winner's rdata (reads only; 0 on a write or an error), set that port's ack=1 and its err flag, then go to RESP.
- RESP (one cycle):
  - The winner's ack and err are high for this cycle only.
  - The winner's rdata holds its value until the next transaction for that port.
  - Go to IDLE. A requester must drop or change req in the cycle after ack.
- Latency: req seen in IDLE at cycle n; memory access in n+1; ack in n+2. Each transaction takes 3 cycles.
- Simultaneous requests:
  - cpu wins. aux waits, with its req held, until the guard fires or cpu goes idle.
  - cpu_stall stays high while cpu waits behind an aux transaction.
- Requests arriving during XFER or RESP are not sampled until IDLE.
- Reset mid-operation:
  - mem_ena is gated with ~rst, so a write in XFER during the rst cycle is suppressed.
  - No ack is issued for the aborted transaction; the FSM returns to IDLE.
- Address arithmetic: word index = (addr - BASE_ADDR) >> 2, computed in 32 bits unsigned. An address below BASE wraps to a large value and is flagged as out of range.

Decomposition:
- Shared constants go in the existing define.v: ENABLED, WRITE_ENABLED, WRITE_DISABLED, DMEM_BASE, DMEM_DEPTH, and the FSM state encodings ST_IDLE=2'd0, ST_XFER=2'd1, ST_RESP=2'd2.
- One sub-module, dmem_addr_check: combinational; inputs addr; outputs legal and word index.
- Arbitration and the FSM stay in dmem_arbiter.

Test Plan:
- cpu write 0xDEADBEEF @0x10010010, then cpu read same addr -> ack at cycle n+2 each time; read returns 0xDEADBEEF; cpu_err=0; mem_wena high for exactly 1 cycle.
- Both req held continuously with STARVE_LIMIT=4 -> grant order cpu,cpu,cpu,cpu,aux,cpu...; aux_ack arrives within 5 transactions; cpu_stall=1 during the aux transaction.
- aux read @0x100102D0 (word 180) after cpu writes 0x5 there -> aux_rdata=0x5; cpu_ack stays 0 throughout.
- cpu read @0x10011000 (one past end), @0x1000FFFC (below base), @0x10010002 (misaligned) -> cpu_ack=1, cpu_err=1, cpu_rdata=0, mem_ena=0 in all cycles.
- cpu write with rst asserted in the XFER cycle -> mem_ena=0, target word unchanged on readback, no cpu_ack; FSM in IDLE on the next cycle.
- Back-to-back cpu reads with req held through ack and then re-presented -> exactly one ack per transaction, 3-cycle spacing, rdata held between acks.
